// File: rtl/riscv_single_top.sv
// riscv_single_top: single-cycle RV32I core with instruction/data memories and exported control nets.
module riscv_ram (
    input  logic        clk,
    input  logic        we,
    input  logic [5:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    logic [31:0] _mem [0:63];
    always_ff @(posedge clk)
        if (we) _mem[addr] <= wd;
    assign rd = _mem[addr];
endmodule

module riscv_imem (
    input  logic        clk,
    input  logic [5:0]  addr,
    output logic [31:0] rd
);
    riscv_ram _mem (.clk(clk), .we(1'b0), .addr(addr), .wd(32'd0), .rd(rd));
endmodule

module riscv_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] _reg [0:31];
    always_ff @(posedge clk)
        if (we && wa != 5'd0) _reg[wa] <= wd;
    assign rd1 = ra1 == 5'd0 ? 32'd0 : _reg[ra1];
    assign rd2 = ra2 == 5'd0 ? 32'd0 : _reg[ra2];
endmodule

module riscv_datapath (
    input  logic        clk,
    input  logic        we,
    input  logic [31:7] instr,
    input  logic [31:0] pc,
    input  logic [2:0]  imm_src,
    input  logic [3:0]  alu_ctrl,
    input  logic        alu_src,
    input  logic [2:0]  res_src,
    input  logic [1:0]  pc_src,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] alu_out,
    output logic [31:0] mem_wd_data,
    output logic [31:0] pc_next
);
    logic [31:0] rs1, imm, b, pc_plus4, pc_target, result;
    riscv_regfile rf (
        .clk(clk), .we(we), .ra1(instr[19:15]), .ra2(instr[24:20]), .wa(instr[11:7]),
        .wd(result), .rd1(rs1), .rd2(mem_wd_data)
    );
    always_comb
        imm = imm_src == 3'd1 ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
              imm_src == 3'd2 ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
              imm_src == 3'd3 ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
              imm_src == 3'd4 ? {instr[31:12], 12'd0} :
                                {{20{instr[31]}}, instr[31:20]};
    assign b = alu_src ? imm : mem_wd_data;
    always_comb
        case (alu_ctrl)
            4'd0:    alu_out = rs1 + b;
            4'd1:    alu_out = rs1 - b;
            4'd2:    alu_out = rs1 & b;
            4'd3:    alu_out = rs1 | b;
            4'd4:    alu_out = rs1 ^ b;
            4'd5:    alu_out = {31'd0, $signed(rs1) < $signed(b)};
            4'd6:    alu_out = {31'd0, rs1 < b};
            4'd7:    alu_out = rs1 << b[4:0];
            4'd8:    alu_out = rs1 >> b[4:0];
            4'd9:    alu_out = $signed(rs1) >>> b[4:0];
            default: alu_out = 32'd0;
        endcase
    assign pc_plus4  = pc + 32'd4;
    assign pc_target = pc + imm;
    always_comb
        result = res_src == 3'd1 ? mem_rd_data :
                 res_src == 3'd2 ? pc_plus4 :
                 res_src == 3'd3 ? imm :
                 res_src == 3'd4 ? pc_target : alu_out;
    always_comb
        pc_next = pc_src == 2'd1 ? pc_target :
                  pc_src == 2'd2 ? {alu_out[31:1], 1'b0} : pc_plus4;
endmodule

module riscv_single_top (
    output logic        reg_we,
    output logic        mem_we,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src,
    output logic [2:0]  res_src,
    output logic [1:0]  pc_src,
    output logic [31:0] instr,
    output logic [31:0] alu_out,
    output logic [31:0] mem_rd_data,
    output logic [31:0] mem_wd_data,
    output logic [31:0] pc,
    input  logic        rst,
    input  logic        clk
);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [3:0]  alu_fn;
    logic [31:0] pc_next;
    logic        taken;
    assign op = instr[6:0];
    assign f3 = instr[14:12];
    riscv_imem instr_mem (.clk(clk), .addr(pc[7:2]), .rd(instr));
    // State only changes out of reset, so bench preloads made while rst is low survive.
    riscv_ram data_mem (
        .clk(clk), .we(mem_we & rst), .addr(alu_out[7:2]), .wd(mem_wd_data), .rd(mem_rd_data)
    );
    riscv_datapath dp (
        .clk(clk), .we(reg_we & rst), .instr(instr[31:7]), .pc(pc), .imm_src(imm_src),
        .alu_ctrl(alu_ctrl), .alu_src(alu_src), .res_src(res_src), .pc_src(pc_src),
        .mem_rd_data(mem_rd_data), .alu_out(alu_out), .mem_wd_data(mem_wd_data), .pc_next(pc_next)
    );
    // op[5] separates R-type from OP-IMM, whose bit 30 is immediate data except for srai.
    always_comb
        alu_fn = f3 == 3'd0 ? {3'd0, op[5] & instr[30]} :
                 f3 == 3'd1 ? 4'd7 :
                 f3 == 3'd2 ? 4'd5 :
                 f3 == 3'd3 ? 4'd6 :
                 f3 == 3'd4 ? 4'd4 :
                 f3 == 3'd5 ? (instr[30] ? 4'd9 : 4'd8) :
                 f3 == 3'd6 ? 4'd3 : 4'd2;
    always_comb begin
        reg_we   = 1'b0;
        mem_we   = 1'b0;
        imm_src  = 3'd0;
        alu_ctrl = 4'd0;
        alu_src  = 1'b0;
        res_src  = 3'd0;
        case (op)
            7'b0000011: begin reg_we = 1'b1; alu_src = 1'b1; res_src = 3'd1; end
            7'b0100011: begin mem_we = 1'b1; imm_src = 3'd1; alu_src = 1'b1; end
            7'b0110011: begin reg_we = 1'b1; alu_ctrl = alu_fn; end
            7'b0010011: begin reg_we = 1'b1; alu_src = 1'b1; alu_ctrl = alu_fn; end
            7'b1100011: begin imm_src = 3'd2; alu_ctrl = f3[2] ? (f3[1] ? 4'd6 : 4'd5) : 4'd1; end
            7'b1101111: begin reg_we = 1'b1; imm_src = 3'd3; res_src = 3'd2; end
            7'b1100111: begin reg_we = 1'b1; alu_src = 1'b1; res_src = 3'd2; end
            7'b0110111: begin reg_we = 1'b1; imm_src = 3'd4; res_src = 3'd3; end
            7'b0010111: begin reg_we = 1'b1; imm_src = 3'd4; res_src = 3'd4; end
            default: ;
        endcase
    end
    // Odd funct3 inverts the condition: bne/bge/bgeu.
    assign taken = (f3[2] ? alu_out[0] : alu_out == 32'd0) ^ f3[0];
    always_comb
        pc_src = op == 7'b1100011 ? {1'b0, taken} :
                 op == 7'b1101111 ? 2'd1 :
                 op == 7'b1100111 ? 2'd2 : 2'd0;
    always_ff @(posedge clk or negedge rst)
        if (!rst) pc <= 32'd0;
        else pc <= pc_next;
endmodule

// File: tb/tb_riscv_single_top.sv
// tb_riscv_single_top: directed per-instruction vectors plus multi-cycle program sequences.
module tb_riscv_single_top;
    logic        clk = 1'b0, rst = 1'b0;
    logic        reg_we, mem_we, alu_src;
    logic [2:0]  imm_src, res_src;
    logic [3:0]  alu_ctrl;
    logic [1:0]  pc_src;
    logic [31:0] instr, alu_out, mem_rd_data, mem_wd_data, pc;

    riscv_single_top dut (
        .reg_we(reg_we), .mem_we(mem_we), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
        .alu_src(alu_src), .res_src(res_src), .pc_src(pc_src), .instr(instr),
        .alu_out(alu_out), .mem_rd_data(mem_rd_data), .mem_wd_data(mem_wd_data),
        .pc(pc), .rst(rst), .clk(clk)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] S = 32'h5a5a5a5a;
    localparam logic [31:0] NOP = 32'h00000013;

    // care: [3] imm_src, [2] alu_ctrl, [1] alu_src, [0] res_src
    typedef struct {
        string       nm;
        logic [31:0] ins, a, b, rd, npc;
        logic        rwe;
        logic [2:0]  imm;
        logic [3:0]  alu;
        logic        asrc;
        logic [2:0]  res;
        logic [1:0]  psrc;
        logic [3:0]  care;
    } vec_t;

    vec_t vt[$];
    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) dut.instr_mem._mem._mem[i] = NOP;
        dut.dp.rf._reg[0] = 32'h77;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt.push_back('{"add",   32'h002081b3, 32'h80000000, 32'h1, 32'h80000001, 32'h4, 1'b1, 3'd0, 4'd0, 1'b0, 3'd0, 2'd0, 4'b0111});
        vt.push_back('{"sub",   32'h402081b3, 32'h80000000, 32'h1, 32'h7fffffff, 32'h4, 1'b1, 3'd0, 4'd1, 1'b0, 3'd0, 2'd0, 4'b0111});
        vt.push_back('{"and",   32'h0020f1b3, 32'hf0f0ff00, 32'h0ff0f0f0, 32'h00f0f000, 32'h4, 1'b1, 3'd0, 4'd2, 1'b0, 3'd0, 2'd0, 4'b0111});
        vt.push_back('{"or",    32'h0020e1b3, 32'h80000000, 32'h1, 32'h80000001, 32'h4, 1'b1, 3'd0, 4'd3, 1'b0, 3'd0, 2'd0, 4'b0111});
        vt.push_back('{"xor",   32'h0020c1b3, 32'hff00ff00, 32'h0ff00ff0, 32'hf0f0f0f0, 32'h4, 1'b1, 3'd0, 4'd4, 1'b0, 3'd0, 2'd0, 4'b0111});
        vt.push_back('{"slt",   32'h0020a1b3, 32'h80000000, 32'h1, 32'h1, 32'h4, 1'b1, 3'd0, 4'd5, 1'b0, 3'd0, 2'd0, 4'b0111});
        vt.push_back('{"sltu",  32'h0020b1b3, 32'h80000000, 32'h1, 32'h0, 32'h4, 1'b1, 3'd0, 4'd6, 1'b0, 3'd0, 2'd0, 4'b0111});
        vt.push_back('{"sll",   32'h002091b3, 32'h3, 32'h24, 32'h30, 32'h4, 1'b1, 3'd0, 4'd7, 1'b0, 3'd0, 2'd0, 4'b0111});
        vt.push_back('{"srl",   32'h0020d1b3, 32'h80000000, 32'h1, 32'h40000000, 32'h4, 1'b1, 3'd0, 4'd8, 1'b0, 3'd0, 2'd0, 4'b0111});
        vt.push_back('{"sra",   32'h4020d1b3, 32'h80000000, 32'h1, 32'hc0000000, 32'h4, 1'b1, 3'd0, 4'd9, 1'b0, 3'd0, 2'd0, 4'b0111});
        vt.push_back('{"addi",  32'hfff08193, 32'h80000000, 32'h1, 32'h7fffffff, 32'h4, 1'b1, 3'd0, 4'd0, 1'b1, 3'd0, 2'd0, 4'b1111});
        vt.push_back('{"addi0", 32'h00700193, 32'h80000000, 32'h1, 32'h7, 32'h4, 1'b1, 3'd0, 4'd0, 1'b1, 3'd0, 2'd0, 4'b1111});
        vt.push_back('{"xori",  32'hfff0c193, 32'h0f0f0f0f, 32'h1, 32'hf0f0f0f0, 32'h4, 1'b1, 3'd0, 4'd4, 1'b1, 3'd0, 2'd0, 4'b1111});
        vt.push_back('{"srai",  32'h4040d193, 32'h80000000, 32'h1, 32'hf8000000, 32'h4, 1'b1, 3'd0, 4'd9, 1'b1, 3'd0, 2'd0, 4'b1111});
        vt.push_back('{"lui",   32'h123451b7, 32'h80000000, 32'h1, 32'h12345000, 32'h4, 1'b1, 3'd4, 4'd0, 1'b0, 3'd3, 2'd0, 4'b1001});
        vt.push_back('{"auipc", 32'h00001197, 32'h80000000, 32'h1, 32'h00001000, 32'h4, 1'b1, 3'd4, 4'd0, 1'b0, 3'd4, 2'd0, 4'b1001});
        vt.push_back('{"jal",   32'h010001ef, 32'h80000000, 32'h1, 32'h4, 32'h10, 1'b1, 3'd3, 4'd0, 1'b0, 3'd2, 2'd1, 4'b1001});
        vt.push_back('{"jalr",  32'h000081e7, 32'h80000005, 32'h1, 32'h4, 32'h80000004, 1'b1, 3'd0, 4'd0, 1'b1, 3'd2, 2'd2, 4'b1111});
        vt.push_back('{"beq_n", 32'h00208463, 32'h80000000, 32'h1, S, 32'h4, 1'b0, 3'd2, 4'd1, 1'b0, 3'd0, 2'd0, 4'b1110});
        vt.push_back('{"beq_t", 32'h00108463, 32'h80000000, 32'h1, S, 32'h8, 1'b0, 3'd2, 4'd1, 1'b0, 3'd0, 2'd1, 4'b1110});
        vt.push_back('{"bne_t", 32'h00209463, 32'h80000000, 32'h1, S, 32'h8, 1'b0, 3'd2, 4'd1, 1'b0, 3'd0, 2'd1, 4'b1110});
        vt.push_back('{"blt_t", 32'h0020c463, 32'h80000000, 32'h1, S, 32'h8, 1'b0, 3'd2, 4'd5, 1'b0, 3'd0, 2'd1, 4'b1110});
        vt.push_back('{"bge_n", 32'h0020d463, 32'h80000000, 32'h1, S, 32'h4, 1'b0, 3'd2, 4'd5, 1'b0, 3'd0, 2'd0, 4'b1110});
        vt.push_back('{"bltu_n",32'h0020e463, 32'h80000000, 32'h1, S, 32'h4, 1'b0, 3'd2, 4'd6, 1'b0, 3'd0, 2'd0, 4'b1110});
        vt.push_back('{"bgeu_t",32'h0020f463, 32'h80000000, 32'h1, S, 32'h8, 1'b0, 3'd2, 4'd6, 1'b0, 3'd0, 2'd1, 4'b1110});
        vt.push_back('{"nop7f", 32'h0000007f, 32'h80000000, 32'h1, S, 32'h4, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 2'd0, 4'b0000});

        foreach (vt[k]) begin
            hold_reset();
            chk($sformatf("%s.rst_pc", vt[k].nm), pc, 32'h0);
            dut.instr_mem._mem._mem[0] = vt[k].ins;
            dut.dp.rf._reg[1] = vt[k].a;
            dut.dp.rf._reg[2] = vt[k].b;
            dut.dp.rf._reg[3] = S;
            release_reset();
            chk($sformatf("%s.reg_we", vt[k].nm), {31'd0, reg_we}, {31'd0, vt[k].rwe});
            chk($sformatf("%s.mem_we", vt[k].nm), {31'd0, mem_we}, 32'h0);
            chk($sformatf("%s.pc_src", vt[k].nm), {30'd0, pc_src}, {30'd0, vt[k].psrc});
            if (vt[k].care[3]) chk($sformatf("%s.imm_src", vt[k].nm), {29'd0, imm_src}, {29'd0, vt[k].imm});
            if (vt[k].care[2]) chk($sformatf("%s.alu_ctrl", vt[k].nm), {28'd0, alu_ctrl}, {28'd0, vt[k].alu});
            if (vt[k].care[1]) chk($sformatf("%s.alu_src", vt[k].nm), {31'd0, alu_src}, {31'd0, vt[k].asrc});
            if (vt[k].care[0]) chk($sformatf("%s.res_src", vt[k].nm), {29'd0, res_src}, {29'd0, vt[k].res});
            step();
            chk($sformatf("%s.x3", vt[k].nm), dut.dp.rf._reg[3], vt[k].rd);
            chk($sformatf("%s.pc", vt[k].nm), pc, vt[k].npc);
        end

        // slti sequence
        hold_reset();
        dut.instr_mem._mem._mem[0] = 32'h0022a213;
        dut.instr_mem._mem._mem[1] = 32'h0023a213;
        dut.instr_mem._mem._mem[2] = 32'h0044a213;
        dut.dp.rf._reg[4] = S;
        dut.dp.rf._reg[5] = 32'h8;
        dut.dp.rf._reg[7] = 32'hfffffff8;
        dut.dp.rf._reg[9] = 32'h2;
        release_reset();
        chk("slti.imm_src", {29'd0, imm_src}, 32'h0);
        chk("slti.alu_src", {31'd0, alu_src}, 32'h1);
        chk("slti.alu_ctrl", {28'd0, alu_ctrl}, 32'h5);
        chk("slti.reg_we", {31'd0, reg_we}, 32'h1);
        step();
        chk("slti1.x4", dut.dp.rf._reg[4], 32'h0);
        step();
        chk("slti2.x4", dut.dp.rf._reg[4], 32'h1);
        dut.dp.rf._reg[4] = S;
        step();
        chk("slti3.x4", dut.dp.rf._reg[4], 32'h1);

        // store then load
        hold_reset();
        dut.instr_mem._mem._mem[0] = 32'h00202423;
        dut.instr_mem._mem._mem[1] = 32'h00802183;
        dut.dp.rf._reg[2] = 32'hdeadbeef;
        dut.dp.rf._reg[3] = S;
        release_reset();
        chk("sw.mem_we", {31'd0, mem_we}, 32'h1);
        chk("sw.reg_we", {31'd0, reg_we}, 32'h0);
        chk("sw.alu_out", alu_out, 32'h8);
        chk("sw.wd", mem_wd_data, 32'hdeadbeef);
        step();
        @(negedge clk);
        chk("lw.mem_we", {31'd0, mem_we}, 32'h0);
        chk("lw.rd_data", mem_rd_data, 32'hdeadbeef);
        step();
        chk("lw.x3", dut.dp.rf._reg[3], 32'hdeadbeef);

        // control flow: beq, bne, lui, auipc, jalr, jal, jalr
        hold_reset();
        dut.instr_mem._mem._mem[0] = 32'h00000463;
        dut.instr_mem._mem._mem[1] = 32'h010000ef;
        dut.instr_mem._mem._mem[2] = 32'h00001463;
        dut.instr_mem._mem._mem[3] = 32'h12345337;
        dut.instr_mem._mem._mem[4] = 32'h00001397;
        dut.instr_mem._mem._mem[5] = 32'h00008067;
        dut.dp.rf._reg[1] = 32'h5;
        release_reset();
        chk("beq.pc_src", {30'd0, pc_src}, 32'h1);
        step();
        chk("beq.pc", pc, 32'h8);
        @(negedge clk);
        chk("bne.pc_src", {30'd0, pc_src}, 32'h0);
        step();
        chk("bne.pc", pc, 32'hc);
        step();
        chk("lui.x6", dut.dp.rf._reg[6], 32'h12345000);
        chk("lui.pc", pc, 32'h10);
        step();
        chk("auipc.x7", dut.dp.rf._reg[7], 32'h00001010);
        @(negedge clk);
        chk("jalr1.pc_src", {30'd0, pc_src}, 32'h2);
        step();
        chk("jalr1.pc", pc, 32'h4);
        step();
        chk("jal.x1", dut.dp.rf._reg[1], 32'h8);
        chk("jal.pc", pc, 32'h14);
        step();
        chk("jalr2.pc", pc, 32'h8);

        // reset asserted mid-program
        hold_reset();
        dut.instr_mem._mem._mem[0] = 32'h00150513;
        dut.instr_mem._mem._mem[1] = 32'h00158593;
        dut.instr_mem._mem._mem[2] = 32'h00500013;
        dut.dp.rf._reg[10] = 32'h0;
        dut.dp.rf._reg[11] = 32'h0;
        release_reset();
        step();
        step();
        step();
        chk("run.x10", dut.dp.rf._reg[10], 32'h1);
        chk("run.x11", dut.dp.rf._reg[11], 32'h1);
        chk("addi_x0.x0", dut.dp.rf._reg[0], 32'h77);
        chk("run.pc", pc, 32'hc);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst.pc", pc, 32'h0);
        chk("mid_rst.x10", dut.dp.rf._reg[10], 32'h1);
        step();
        chk("held.pc", pc, 32'h0);
        chk("held.x10", dut.dp.rf._reg[10], 32'h1);
        chk("held.x11", dut.dp.rf._reg[11], 32'h1);
        release_reset();
        step();
        chk("resume.x10", dut.dp.rf._reg[10], 32'h2);
        chk("resume.pc", pc, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
